// File: rtl/mem_pkg.sv
// Shared types and encodings for the memory wait-state stage.
// Holds the request payload and the fault predicate used by the controller.
package mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;
    localparam logic SZ_WORD   = 1'b0;
    localparam logic SZ_BYTE   = 1'b1;

    typedef struct packed {
        logic              rw;
        logic              size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Last byte touched is computed one bit wider so addresses near 2^32 cannot wrap.
    function automatic logic access_fault(input mem_req_t req, input int unsigned depth);
        logic [ADDR_W:0] last;
        logic            misaligned;
        last       = {1'b0, req.addr} + ((req.size == SZ_WORD) ? (ADDR_W+1)'(3) : (ADDR_W+1)'(0));
        misaligned = (req.size == SZ_WORD) && (req.addr[1:0] != 2'b00);
        return misaligned || (last >= (ADDR_W+1)'(depth));
    endfunction

endpackage

// File: rtl/byte_ram.sv
// DEPTH-byte storage with a synchronous word/byte write port and a
// combinational big-endian 4-byte read port.
module byte_ram
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 128
) (
    input  logic                                     clock,
    input  logic                                     we,
    input  logic                                     wsize,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] waddr,
    input  logic [DATA_W-1:0]                        wdata,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] raddr,
    output logic [DATA_W-1:0]                        rdata_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0] mem_q [DEPTH];

    function automatic logic [AW:0] byte_idx(input logic [AW-1:0] base, input int unsigned k);
        return {1'b0, base} + (AW+1)'(k);
    endfunction

    // Out-of-range lanes read as zero; the controller never commits them.
    always_comb begin
        logic [AW:0] idx;
        rdata_c = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = byte_idx(raddr, k);
            if (idx < (AW+1)'(DEPTH)) begin
                rdata_c[31-8*k -: 8] = mem_q[AW'(idx)];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (we) begin
            if (wsize == SZ_BYTE) begin
                mem_q[waddr] <= wdata[7:0];
            end else begin
                for (int unsigned k = 0; k < 4; k++) begin
                    if (byte_idx(waddr, k) < (AW+1)'(DEPTH)) begin
                        mem_q[AW'(byte_idx(waddr, k))] <= wdata[31-8*k -: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mem_wait_ctrl.sv
// Memory-side bus stage: accepts one request at a time, inserts WAIT wait
// states, then completes with a one-cycle ready pulse (fault on rejected access).
module mem_wait_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned WAIT  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              rw,
    input  logic              size,
    input  logic [ADDR_W-1:0] abus,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              fault,
    output logic              busy
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mem_req_t          req_q, req_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              fault_q, fault_d;
    logic              busy_q, busy_d;

    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata_c;
    logic              fault_c;

    assign fault_c = access_fault(req_q, DEPTH);

    byte_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .we      (ram_we),
        .wsize   (req_q.size),
        .waddr   (AW'(req_q.addr)),
        .wdata   (req_q.wdata),
        .raddr   (AW'(req_q.addr)),
        .rdata_c (ram_rdata_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and completion logic; the array write fires on the edge that raises ready.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        fault_d = 1'b0;
        ram_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    req_d.rw    = rw;
                    req_d.size  = size;
                    req_d.addr  = abus;
                    req_d.wdata = wdata;
                    cnt_d       = CNT_W'(WAIT);
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    ready_d = 1'b1;
                    state_d = DONE;
                    if (fault_c) begin
                        fault_d = 1'b1;
                        rdata_d = '0;
                    end else if (req_q.rw == MEM_READ) begin
                        rdata_d = (req_q.size == SZ_BYTE) ? {24'h0, ram_rdata_c[31:24]}
                                                          : ram_rdata_c;
                    end else begin
                        ram_we = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign fault = fault_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Scoreboard bench for mem_wait_ctrl at WAIT=2, WAIT=0 and WAIT=15.
module tb_mem_wait_ctrl;

    localparam int WAITS [3] = '{2, 0, 15};

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        fault;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_s    [3];
    logic        rw_s    [3];
    logic        size_s  [3];
    logic [31:0] abus_s  [3];
    logic [31:0] wdata_s [3];
    logic [31:0] rdata_s [3];
    logic        ready_s [3];
    logic        fault_s [3];
    logic        busy_s  [3];

    exp_t        exp_q[$];
    logic [31:0] rd_model [3];
    int          acc_cyc  [3];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          tmo_cnt = 0;
    logic        hold = 1'b0;
    logic        final_req = 1'b0;
    logic        final_done = 1'b0;
    int          last_rdy = 0;
    logic        last_valid = 1'b0;
    logic        prev_low = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_wait_ctrl #(.DEPTH(128), .WAIT(2)) u0 (
        .clock(clk), .reset(rst), .en(en_s[0]), .rw(rw_s[0]), .size(size_s[0]),
        .abus(abus_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]),
        .ready(ready_s[0]), .fault(fault_s[0]), .busy(busy_s[0]));

    mem_wait_ctrl #(.DEPTH(128), .WAIT(0)) u1 (
        .clock(clk), .reset(rst), .en(en_s[1]), .rw(rw_s[1]), .size(size_s[1]),
        .abus(abus_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]),
        .ready(ready_s[1]), .fault(fault_s[1]), .busy(busy_s[1]));

    mem_wait_ctrl #(.DEPTH(128), .WAIT(15)) u2 (
        .clock(clk), .reset(rst), .en(en_s[2]), .rw(rw_s[2]), .size(size_s[2]),
        .abus(abus_s[2]), .wdata(wdata_s[2]), .rdata(rdata_s[2]),
        .ready(ready_s[2]), .fault(fault_s[2]), .busy(busy_s[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every ready pulse and checks reset/handshake timing.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                chk("reset_rdata", rdata_s[i], 32'h0);
                chk("reset_ctl", {29'h0, ready_s[i], fault_s[i], busy_s[i]}, 32'h0);
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (ready_s[i]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ready", 32'(i), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_inst", 32'(i), 32'(e.inst));
                        chk("resp_rdata", rdata_s[i], e.rdata);
                        chk("resp_fault", {31'h0, fault_s[i]}, {31'h0, e.fault});
                        chk("resp_latency", 32'(cyc - acc_cyc[i]), 32'(e.lat));
                    end
                    if (i == 1 && hold) begin
                        if (last_valid) chk("ready_period", 32'(cyc - last_rdy), 32'd3);
                        last_rdy   = cyc;
                        last_valid = 1'b1;
                    end
                end
                if (!busy_s[i] && en_s[i]) acc_cyc[i] = cyc + 1;
            end
            if (hold) begin
                if (!busy_s[1]) chk("busy_low_run", {31'h0, prev_low}, 32'h0);
                prev_low = !busy_s[1];
            end else begin
                prev_low   = 1'b0;
                last_valid = 1'b0;
            end
            if (final_req && !final_done) begin
                chk("queue_drained", 32'(exp_q.size()), 32'h0);
                chk("no_timeout", 32'(tmo_cnt), 32'h0);
                final_done = 1'b1;
            end
        end
    end

    task automatic wait_idle(input int i);
        int n = 0;
        while (busy_s[i] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy_s[i]) tmo_cnt++;
    endtask

    // Issue one request and push its hand-computed response; inputs are scrambled while busy.
    task automatic issue(input int i, input logic r, input logic sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd_exp, input logic flt);
        exp_t e;
        wait_idle(i);
        en_s[i] = 1'b1; rw_s[i] = r; size_s[i] = sz; abus_s[i] = a; wdata_s[i] = wd;
        if (flt) rd_model[i] = 32'h0;
        else if (r) rd_model[i] = rd_exp;
        e.inst = i; e.rdata = rd_model[i]; e.fault = flt; e.lat = WAITS[i] + 1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        en_s[i] = 1'b0; rw_s[i] = ~r; size_s[i] = ~sz;
        abus_s[i] = 32'hFFFF_FFFC; wdata_s[i] = 32'h5555_AAAA;
        wait_idle(i);
    endtask

    initial begin
        exp_t e;
        int n;
        for (int i = 0; i < 3; i++) begin
            en_s[i] = 1'b0; rw_s[i] = 1'b0; size_s[i] = 1'b0;
            abus_s[i] = 32'h0; wdata_s[i] = 32'h0; rd_model[i] = 32'h0; acc_cyc[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // WAIT=2: word/byte read-write, big-endian packing, faults and boundaries.
        issue(0, 1'b0, 1'b0, 32'h10, 32'h1234_5678, 32'h0,          1'b0);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0,         32'h1234_5678,  1'b0);
        issue(0, 1'b1, 1'b1, 32'h11, 32'h0,         32'h0000_0034,  1'b0);
        issue(0, 1'b1, 1'b1, 32'h10, 32'h0,         32'h0000_0012,  1'b0);
        issue(0, 1'b0, 1'b1, 32'h13, 32'hFFFF_FFAB, 32'h0,          1'b0);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0,         32'h1234_56AB,  1'b0);
        issue(0, 1'b0, 1'b1, 32'h7E, 32'h0000_005A, 32'h0,          1'b0);
        issue(0, 1'b0, 1'b1, 32'h7F, 32'h0000_00C3, 32'h0,          1'b0);
        issue(0, 1'b1, 1'b0, 32'h0E, 32'h0,         32'h0,          1'b1);
        issue(0, 1'b1, 1'b0, 32'h7E, 32'h0,         32'h0,          1'b1);
        issue(0, 1'b0, 1'b0, 32'h7E, 32'h1111_1111, 32'h0,          1'b1);
        issue(0, 1'b1, 1'b1, 32'h7E, 32'h0,         32'h0000_005A,  1'b0);
        issue(0, 1'b1, 1'b1, 32'h7F, 32'h0,         32'h0000_00C3,  1'b0);
        issue(0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,  32'h0,          1'b1);
        issue(0, 1'b1, 1'b1, 32'h80, 32'h0,         32'h0,          1'b1);
        issue(0, 1'b0, 1'b0, 32'h7C, 32'h0102_0304, 32'h0,          1'b0);
        issue(0, 1'b1, 1'b0, 32'h7C, 32'h0,         32'h0102_0304,  1'b0);

        // Reset one cycle after accepting a write aborts it.
        issue(0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
        en_s[0] = 1'b1; rw_s[0] = 1'b0; size_s[0] = 1'b0;
        abus_s[0] = 32'h20; wdata_s[0] = 32'hDEAD_BEEF;
        @(posedge clk); #1 en_s[0] = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) rd_model[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        issue(0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

        // WAIT=15: latency of 16 cycles.
        issue(2, 1'b0, 1'b0, 32'h40, 32'hA5A5_5A5A, 32'h0,         1'b0);
        issue(2, 1'b1, 1'b0, 32'h40, 32'h0,         32'hA5A5_5A5A, 1'b0);

        // WAIT=0: preload, then hold en high while abus wobbles during BUSY.
        issue(1, 1'b0, 1'b0, 32'h00, 32'hCAFE_F00D, 32'h0,         1'b0);
        issue(1, 1'b0, 1'b0, 32'h04, 32'h0BAD_BEEF, 32'h0,         1'b0);
        issue(1, 1'b1, 1'b0, 32'h04, 32'h0,         32'h0BAD_BEEF, 1'b0);
        hold = 1'b1;
        en_s[1] = 1'b1; rw_s[1] = 1'b1; size_s[1] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!busy_s[1]) begin
                abus_s[1] = 32'h00;
                e.inst = 1; e.rdata = 32'hCAFE_F00D; e.fault = 1'b0; e.lat = 1;
                exp_q.push_back(e);
            end else begin
                abus_s[1] = 32'h04;
            end
            @(posedge clk); #1;
        end
        en_s[1] = 1'b0;
        hold = 1'b0;
        wait_idle(1);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        final_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
